// File: rtl/keypad_scan_sequencer.sv
// 4x4 matrix keypad scanner: one-hot active-low column drive, 2-flop row sync,
// press/release debounce, hex code + one-cycle strobe. Optional auto-repeat via KEYPAD_AUTOREPEAT_EN.
module keypad_scan_sequencer #(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 2400000,
  parameter int REPEAT_PERIOD   = 600000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypad_row,
  output logic [3:0] keypad_column,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int BASE_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_MAX = (BASE_MAX > REP_MAX) ? BASE_MAX : REP_MAX;
`else
  localparam int CNT_MAX = BASE_MAX;
`endif
  localparam int CW = $clog2(CNT_MAX);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    row_meta_q, row_s_q;
  logic [1:0]    low_row;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Lowest-index low row wins when several rows are pressed together.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!row_s_q[i]) low_row = 2'(i);
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_first_q, rep_first_d;
  logic [CW-1:0] rep_last;
  assign rep_last = rep_first_q ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_PERIOD - 1);
`else
  logic unused_rep;
  assign unused_rep = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_d   = '0;
    rep_first_d = 1'b1;
`endif
    case (state_q)
      SCAN: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (row_s_q != 4'hF) begin
            row_idx_d = low_row;
            state_d   = PRESS_DB;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      PRESS_DB: begin
        if (row_s_q[row_idx_q]) begin
          state_d   = SCAN;
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
        end else if (cnt_q == DB_LAST) begin
          state_d     = HELD;
          cnt_d       = '0;
          key_valid_d = 1'b1;
          key_code_d  = key_map(row_idx_q, col_idx_q);
        end
      end
      HELD: begin
        cnt_d = '0;
        if (row_s_q[row_idx_q]) begin
          state_d = RELEASE_DB;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_first_d = rep_first_q;
          rep_cnt_d   = rep_cnt_q + 1'b1;
          if (rep_cnt_q == rep_last) begin
            key_valid_d = 1'b1;
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
          end
`endif
        end
      end
      RELEASE_DB: begin
        if (!row_s_q[row_idx_q]) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = SCAN;
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      cnt_q       <= '0;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      row_meta_q  <= 4'hF;
      row_s_q     <= 4'hF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      row_meta_q  <= keypad_row;
      row_s_q     <= row_meta_q;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`endif

  assign keypad_column = ~(4'b0001 << col_idx_q);
  assign key_code      = key_code_q;
  assign key_valid     = key_valid_q;
  assign key_held      = (state_q == HELD) || (state_q == RELEASE_DB);

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// Directed bench for keypad_scan_sequencer with a behavioural 4x4 key matrix model.
module tb_keypad_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] keypad_row;
  logic [3:0] keypad_column;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] pressed = '0;  // pressed[row][col]

  int n_chk = 0, n_fail = 0;
  int strobe_cnt = 0, dbl_cnt = 0, nohold_cnt = 0;
  logic prev_v = 1'b0;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int EXP_REP = 4;
`else
  localparam int EXP_REP = 0;
`endif

  keypad_scan_sequencer #(
    .SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_PERIOD(10)
  ) dut (
    .clk(clk), .reset(reset), .keypad_row(keypad_row), .keypad_column(keypad_column),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // A row reads low when any pressed key on it sits in the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++)
      keypad_row[r] = ~|(pressed[r] & ~keypad_column);
  end

  always @(negedge clk) begin
    if (!reset && key_valid) begin
      strobe_cnt++;
      if (prev_v) dbl_cnt++;
      if (!key_held) nohold_cnt++;
    end
    prev_v = key_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!key_valid && n < max);
    if (!key_valid) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_held_fall(input string tag, input int max);
    int n = 0;
    while (key_held && n < max) begin
      tick();
      n++;
    end
    if (key_held) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_col"},   keypad_column, 4'b1110);
    chk({tag, "_code"},  key_code, 4'h0);
    chk({tag, "_valid"}, key_valid, 1'b0);
    chk({tag, "_held"},  key_held, 1'b0);
  endtask

  initial begin
    int n, base, nrep;
    logic [3:0] col_seq [4];
    col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;

    // 1: reset and column rotation
    tick(3);
    chk_reset_vals("rst");
    reset = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) tick();
      chk($sformatf("scan_col%0d", k), keypad_column, col_seq[(k / 4) % 4]);
    end

    // 2: clean press row2/col1
    base = strobe_cnt;
    pressed[2][1] = 1'b1;
    wait_valid("clean", 200, n);
    chk("clean_code", key_code, 4'h8);
    chk("clean_held_rise", key_held, 1'b1);
    tick(15);
    pressed = '0;
    tick(10);
    chk("clean_held_last", key_held, 1'b1);
    tick();
    chk("clean_held_fall", key_held, 1'b0);
    chk("clean_next_col", keypad_column, 4'b1011);
    chk("clean_strobes", strobe_cnt - base, 1);

    // 3: bounce on row0/col3, then a glitch during HELD
    base = strobe_cnt;
    pressed[0][3] = 1'b1;
    tick(5);
    pressed = '0;
    tick(20);
    chk("bounce_none", strobe_cnt - base, 0);
    pressed[0][3] = 1'b1;
    wait_valid("bounce", 60, n);
    chk("bounce_code", key_code, 4'hA);
    tick(5);
    pressed = '0;
    tick(3);
    pressed[0][3] = 1'b1;
    tick(10);
    chk("glitch_held", key_held, 1'b1);
    chk("glitch_strobes", strobe_cnt - base, 1);
    pressed = '0;
    wait_held_fall("bounce", 30);

    // 4: two rows in column 0, then another key while held
    base = strobe_cnt;
    pressed[1][0] = 1'b1;
    pressed[3][0] = 1'b1;
    wait_valid("two", 60, n);
    chk("two_code", key_code, 4'h4);
    pressed[3][2] = 1'b1;
    tick(10);
    chk("two_held", key_held, 1'b1);
    chk("two_code_hold", key_code, 4'h4);
    chk("two_strobes", strobe_cnt - base, 1);
    pressed = '0;
    wait_held_fall("two", 30);

    // 5: reset during PRESS_DB and during HELD
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pressed[0][0] = 1'b1;
    base = strobe_cnt;
    tick(6);
    reset = 1'b1;
    tick();
    chk_reset_vals("rst_pdb");
    chk("rst_pdb_strobes", strobe_cnt - base, 0);
    reset = 1'b0;
    wait_valid("rst_pdb", 40, n);
    chk("rst_pdb_latency", n, 12);
    chk("rst_pdb_code", key_code, 4'h1);
    tick(3);
    reset = 1'b1;
    tick();
    chk_reset_vals("rst_held");
    reset = 1'b0;
    wait_valid("rst_held", 40, n);
    chk("rst_held_latency", n, 12);
    chk("rst_held_code", key_code, 4'h1);
    pressed = '0;
    wait_held_fall("rst_held", 30);
    chk("rst_strobes", strobe_cnt - base, 2);

    // 6: long hold on row3/col1
    pressed[3][1] = 1'b1;
    wait_valid("rpt", 60, n);
    chk("rpt_code0", key_code, 4'h0);
    nrep = 0;
    for (int k = 1; k <= 52; k++) begin
      tick();
      if (key_valid) begin
        nrep++;
        chk($sformatf("rpt_off%0d", k), (k == 20 || k == 30 || k == 40 || k == 50), 1);
        chk("rpt_code", key_code, 4'h0);
      end
    end
    chk("rpt_count", nrep, EXP_REP);
    pressed = '0;
    wait_held_fall("rpt", 30);

    chk("no_double_strobe", dbl_cnt, 0);
    chk("valid_implies_held", nohold_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
